// File: rtl/perceptron_seq.sv
// Two-input XOR-capable MLP (2 hidden + 1 output neuron) evaluated on one shared neuron unit.
// Defining WEIGHT_PROG_EN enables the runtime parameter write path; otherwise the weights are fixed.
module perceptron_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_a,
    input  logic                in_b,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_y,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [W-1:0]        cfg_wdata,
    output logic                cfg_ack,
    output logic [CNT_W-1:0]    eval_cnt
);

    typedef enum logic [2:0] {IDLE, EVAL_H1, EVAL_H2, EVAL_O, HOLD} state_t;

    state_t                state, state_nxt;
    logic                  a_q, b_q, h1, h2;
    logic signed [W-1:0]   prm [0:8];
    logic signed [W-1:0]   w0, w1, bias;
    logic                  x0, x1;
    logic signed [W+1:0]   sum;
    logic                  accept, handshake;

    // XOR network in Q.4: H1 = OR, H2 = AND, O = H1 AND NOT H2
    function automatic logic signed [W-1:0] dflt(input int idx);
        case (idx)
            0, 1, 3, 4, 6: dflt = W'(16);
            5:             dflt = W'(-24);
            7:             dflt = W'(-32);
            default:       dflt = W'(-8);
        endcase
    endfunction

    function automatic logic signed [W+1:0] sext(input logic signed [W-1:0] v);
        sext = {{2{v[W-1]}}, v};
    endfunction

    function automatic logic fire(input logic signed [W+1:0] s);
        fire = (s > 0);
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_comb begin
        w0   = prm[0];
        w1   = prm[1];
        bias = prm[2];
        x0   = a_q;
        x1   = b_q;
        case (state)
            EVAL_H2: begin
                w0   = prm[3];
                w1   = prm[4];
                bias = prm[5];
            end
            EVAL_O: begin
                w0   = prm[6];
                w1   = prm[7];
                bias = prm[8];
                x0   = h1;
                x1   = h2;
            end
            default: ;
        endcase
        sum = (x0 ? sext(w0) : '0) + (x1 ? sext(w1) : '0) + sext(bias);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EVAL_H1;
            EVAL_H1: state_nxt = EVAL_H2;
            EVAL_H2: state_nxt = EVAL_O;
            EVAL_O:  state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            h1       <= 1'b0;
            h2       <= 1'b0;
            out_y    <= 1'b0;
            eval_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    a_q <= in_a;
                    b_q <= in_b;
                end
                EVAL_H1: h1    <= fire(sum);
                EVAL_H2: h2    <= fire(sum);
                EVAL_O:  out_y <= fire(sum);
                HOLD:    if (handshake) eval_cnt <= eval_cnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef WEIGHT_PROG_EN
    logic cfg_commit;
    assign cfg_commit = cfg_we && (state == IDLE) && (cfg_addr <= 4'd8);

    // A write coinciding with acceptance lands before EVAL_H1 reads the table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) prm[i] <= dflt(i);
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= cfg_commit;
            if (cfg_commit) prm[cfg_addr] <= cfg_wdata;
        end
    end
`else
    logic cfg_unused;
    assign cfg_unused = ^{cfg_we, cfg_addr, cfg_wdata};
    assign cfg_ack    = 1'b0;

    always_comb begin
        for (int i = 0; i < 9; i++) prm[i] = dflt(i);
    end
`endif

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed bench for perceptron_seq: XOR defaults, backpressure, programming (when
// WEIGHT_PROG_EN is defined), threshold edge, mid-evaluation reset and counter wrap.
module tb_perceptron_seq;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid, in_a, in_b, in_ready;
    logic             out_valid, out_ready, out_y;
    logic             cfg_we, cfg_ack;
    logic [3:0]       cfg_addr;
    logic [W-1:0]     cfg_wdata;
    logic [CNT_W-1:0] eval_cnt;

    int checks = 0;
    int errors = 0;

    perceptron_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ack   (cfg_ack),
        .eval_cnt  (eval_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer (a,b), measure edges to out_valid, check Y; optionally complete the handshake.
    task automatic do_eval(input logic a, input logic b, input logic exp_y,
                           input bit hs, input string tag);
        int lat;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_y"}, out_y, exp_y);
        if (hs) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [W-1:0] data,
                             input logic exp_ack, input string tag);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
        check({tag, "_ack"}, cfg_ack, exp_ack);
        @(negedge clk);
        check({tag, "_ack_pulse"}, cfg_ack, 0);
    endtask

    initial begin
        logic [CNT_W-1:0] cnt_hold;
        logic             y_hold;
        bit               saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 1'b0;
        in_b      = 1'b0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;

        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_cfg_ack", cfg_ack, 0);
        check("rst_eval_cnt", eval_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Default XOR truth table
        do_eval(1'b0, 1'b0, 1'b0, 1, "xor00");
        do_eval(1'b0, 1'b1, 1'b1, 1, "xor01");
        do_eval(1'b1, 1'b0, 1'b1, 1, "xor10");
        do_eval(1'b1, 1'b1, 1'b0, 1, "xor11");
        check("cnt_after_xor", eval_cnt, 4);

        // Backpressure: result held while out_ready is low
        do_eval(1'b0, 1'b1, 1'b1, 0, "bp");
        cnt_hold = eval_cnt;
        y_hold   = out_y;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_y", out_y, y_hold);
            check("bp_in_ready", in_ready, 0);
            check("bp_cnt", eval_cnt, cnt_hold);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_cnt_inc", eval_cnt, 5);
        check("bp_in_ready_after", in_ready, 1);
        check("bp_valid_after", out_valid, 0);

`ifdef WEIGHT_PROG_EN
        // O = H1 (OR network)
        cfg_write(4'd7, 8'sd0, 1'b1, "wr7");
        cfg_write(4'd8, -8'sd8, 1'b1, "wr8");
        do_eval(1'b1, 1'b1, 1'b1, 1, "or11");
        do_eval(1'b0, 1'b0, 1'b0, 1, "or00");
        cfg_write(4'd9, 8'sd100, 1'b0, "wr_badaddr");

        // Write while busy is dropped
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 1'b1;
        in_b     = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        cfg_we    = 1'b1;
        cfg_addr  = 4'd8;
        cfg_wdata = 8'sd100;
        @(negedge clk);
        cfg_we = 1'b0;
        check("busy_ack", cfg_ack, 0);
        @(negedge clk);
        @(negedge clk);
        check("busy_valid", out_valid, 1);
        check("busy_y", out_y, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        do_eval(1'b0, 1'b0, 1'b0, 1, "busy_unchanged");

        // cfg and input together: bias 8 makes O fire for H1=0
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = 4'd8;
        cfg_wdata = 8'sd8;
        in_valid  = 1'b1;
        in_a      = 1'b0;
        in_b      = 1'b0;
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        check("coin_ack", cfg_ack, 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("coin_valid", out_valid, 1);
        check("coin_y", out_y, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Threshold: a sum of exactly zero is not a firing neuron
        cfg_write(4'd0, 8'sd16, 1'b1, "th0");
        cfg_write(4'd1, 8'sd0, 1'b1, "th1");
        cfg_write(4'd2, -8'sd16, 1'b1, "th2");
        cfg_write(4'd6, 8'sd16, 1'b1, "th6");
        cfg_write(4'd7, 8'sd0, 1'b1, "th7");
        cfg_write(4'd8, -8'sd1, 1'b1, "th8");
        do_eval(1'b1, 1'b0, 1'b0, 1, "thresh10");
        check("thresh_h1", dut.h1, 0);
`else
        // Without the write path, cfg writes are ignored
        cfg_write(4'd8, 8'sd100, 1'b0, "nowr");
        do_eval(1'b1, 1'b1, 1'b0, 1, "nowr11");
`endif

        // Reset while in EVAL_H2
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 1'b1;
        in_b     = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cnt", eval_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("mid_rst_no_output", saw_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_cnt_after", eval_cnt, 0);
        do_eval(1'b1, 1'b1, 1'b0, 1, "dflt11");
        do_eval(1'b1, 1'b0, 1'b1, 1, "dflt10");

        // Counter wrap: 2 done above, 254 more reach 0
        out_ready = 1'b1;
        for (int n = 2; n < 256; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = n[0];
            in_b     = n[1];
            @(negedge clk);
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
            if (n == 254) check("cnt_255", eval_cnt, 255);
        end
        out_ready = 1'b0;
        check("cnt_wrap", eval_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_seq.md
PERCEPTRON_SEQ -- requirements
Module: perceptron_seq

Interface
REQ-001 SHALL have parameter W, default 8, meaning signed weight/bias width in Q(W-4).4 fixed point.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the evaluation counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning an operand pair is offered.
REQ-006 SHALL have port in_a, input, 1, meaning network input A.
REQ-007 SHALL have port in_b, input, 1, meaning network input B.
REQ-008 SHALL have port in_ready, output, 1, meaning the block can accept an operand pair.
REQ-009 SHALL have port out_valid, output, 1, meaning result Y is presented.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts Y.
REQ-011 SHALL have port out_y, output, 1, meaning network output Y.
REQ-012 SHALL have port cfg_we, input, 1, meaning parameter write strobe.
REQ-013 SHALL have port cfg_addr, input, 4, meaning parameter index 0..8.
REQ-014 SHALL have port cfg_wdata, input, W, meaning signed parameter value.
REQ-015 SHALL have port cfg_ack, output, 1, meaning one-cycle pulse when a write commits.
REQ-016 SHALL have port eval_cnt, output, CNT_W, meaning number of completed output handshakes.

Function
REQ-017 SHALL hold nine signed parameters at these indices: 0-2 = H1 {wa, wb, bias}, 3-5 = H2 {wa, wb, bias}, 6-8 = O {wh1, wh2, bias}.
REQ-018 SHALL evaluate all three neurons on one shared neuron unit computing sum = w0*x0 + w1*x1 + bias in W+2-bit signed arithmetic, where x0 and x1 are single bits, so the sum cannot overflow.
REQ-019 SHALL threshold each neuron result as 1 only when sum > 0; a sum of exactly 0 SHALL yield 0.
REQ-020 SHALL implement the state machine IDLE -> EVAL_H1 -> EVAL_H2 -> EVAL_O -> HOLD -> IDLE.
REQ-021 SHALL drive in_ready high only in IDLE, and SHALL capture in_a/in_b on the edge where in_valid && in_ready.
REQ-022 SHALL evaluate one neuron per cycle in the states EVAL_H1, EVAL_H2 and EVAL_O, storing H1 and H2 in registers.
REQ-023 SHALL assert out_valid from the third edge after acceptance (in HOLD) and SHALL hold out_y stable until out_valid && out_ready.
REQ-024 SHALL, on the output handshake, return to IDLE and increment eval_cnt, which wraps from 2^CNT_W-1 to 0.
REQ-025 SHALL not allow back-to-back overlap: a new input is accepted no earlier than the cycle after the output handshake.
REQ-026 SHALL commit a cfg write only when the FSM is in IDLE and cfg_addr <= 8, pulsing cfg_ack on the next cycle.
REQ-027 SHALL ignore, without ack, any cfg write outside IDLE or with cfg_addr > 8.
REQ-028 SHALL give cfg priority when cfg_we and in_valid coincide in IDLE: the write commits and the input is still accepted, with the evaluation using the new value.

Reset
REQ-029 SHALL, on rst_n low, immediately force: FSM = IDLE, out_valid = 0, out_y = 0, cfg_ack = 0, eval_cnt = 0, H1 = H2 = 0.
REQ-030 SHALL set in_ready = 1 after reset release.
REQ-031 SHALL reset the parameters to XOR defaults in Q.4: H1 {16, 16, -8}, H2 {16, 16, -24}, O {16, -32, -8}.
REQ-032 SHALL abort any in-flight evaluation on reset assertion mid-operation and produce no output for it.

Configuration
REQ-033 SHALL compile the cfg write path in only when WEIGHT_PROG_EN is defined.
REQ-034 SHALL, without WEIGHT_PROG_EN, keep the cfg ports present, hard-wire the parameters to the REQ-031 defaults, ignore cfg_we and hold cfg_ack at 0.

Verification
REQ-035 SHALL verify the defaults: inputs (0,0), (0,1), (1,0), (1,1) -> out_y 0, 1, 1, 0, with each out_valid 3 edges after acceptance.
REQ-036 SHALL verify backpressure: out_ready held low 5 cycles -> out_valid and out_y stable, in_ready 0, eval_cnt unchanged until the handshake.
REQ-037 SHALL verify programming (WEIGHT_PROG_EN): write addr 7 = 0 and addr 8 = -8 -> output equals H1 (OR): (1,1) -> 1; a cfg write while busy -> no cfg_ack and no change.
REQ-038 SHALL verify the threshold edge: program H1 = {16, 0, -16} and O = {16, 0, -1} -> input (1,0) gives H1 = 0 (sum = 0) and Y = 0.
REQ-039 SHALL verify reset mid-operation: assert rst_n low in EVAL_H2 -> out_valid never rises; after release, in_ready = 1, eval_cnt = 0, defaults restored.
REQ-040 SHALL verify counter wrap: 256 transactions with CNT_W = 8 -> eval_cnt returns to 0.
